search_pipe_arb_ctrl: RTL
=========================

Name: search_pipe_arb_ctrl

Overview:
Sequencer and arbiter for a 2-stage registered datapath whose flops use async active-low reset.
- Shares the pipeline input between two requesters (A, B) with round-robin arbitration.
- Moves data through the stages under an output valid/ready handshake.
- Generates a staged reset release (pipe_rst_n) for downstream reset-pin (RN) flops after global reset or a flush.

Parameters:
- WIDTH, 1, data width of each requester and of the pipeline.
- RST_HOLD, 4, cycles pipe_rst_n stays low after reset release or flush; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A has data.
- data_a  input  WIDTH  requester A data.
- req_b  input  1  requester B has data.
- data_b  input  WIDTH  requester B data.
- gnt_a  output  1  combinational; A's data is accepted at this clock edge.
- gnt_b  output  1  combinational; B's data is accepted at this clock edge.
- flush  input  1  synchronous; drop pipeline contents and re-run the reset hold.
- out_valid  output  1  stage-2 holds valid data.
- out_data  output  WIDTH  stage-2 data.
- out_ready  input  1  consumer accepts out_data at this edge when out_valid=1.
- pipe_rst_n  output  1  registered reset for downstream datapath RN pins.
- busy  output  1  high when state≠RUN or any stage valid.

Behaviour:
- Reset (rst=0, async): state=HOLD, hold counter=0, v1=v2=0, s1/s2 data=0, prio=A, pipe_rst_n=0.
  - Resulting outputs: out_valid=0, out_data=0, gnt_a=gnt_b=0, busy=1.
- FSM states: HOLD, RUN.
- HOLD:
  - Counter increments each edge; no grants.
  - At the edge where counter==RST_HOLD-1: state→RUN, pipe_rst_n→1, counter→0.
  - Result: pipe_rst_n is low for exactly RST_HOLD edges after rst deasserts.
- RUN → HOLD on any edge with flush=1:
  - v1=v2=0; data regs→0; pipe_rst_n→0; counter→0; prio unchanged.
  - flush in HOLD restarts the counter at 0.
- Stage advance:
  - adv2 = v2 & out_ready.
  - s2 can load = !v2 | adv2.
  - adv1 = v1 & (s2 can load).
  - s1 can accept = state==RUN & !flush & (!v1 | adv1).
- Grant:
  - Only when s1 can accept and at least one request is present.
  - One requester only; with only one requesting, that one wins.
  - With both requesting, the prio holder wins; prio then flips to the loser.
  - prio updates only on a grant.
  - gnt_x is purely combinational from req_x, state, flush, v1, v2 and out_ready. Requesters must hold req/data until granted.
- Edge updates:
  - Grant: s1←data, v1←1.
  - adv1 without grant: v1←0.
  - adv1: s2←s1, v2←1.
  - adv2 without adv1: v2←0.
- Timing: out_valid/out_data come straight from v2/s2. A grant at the end of cycle 0 gives out_valid in cycle 2.
- Throughput: 1 item per cycle when out_ready=1.
- Full (v1=v2=1), out_ready=0:
  - No grant; data held stable.
  - out_valid must not drop without a handshake.
- Full with out_ready=1: grant allowed in the same cycle (pass-through).
- Simultaneous flush with req and out_ready: flush wins; no grant, no output transfer counted.
- out_data holds its last value when out_valid=0 (except cleared by reset/flush).
- Reset mid-operation: all state cleared immediately; outputs reach reset values without a clock.

Test Plan:
- RST_HOLD=4; release rst before edge 1 → pipe_rst_n rises after edge 4, busy=1 until then; req_a held from cycle 0 gets gnt_a first in cycle 4.
- RUN, out_ready=1, req_a=req_b=1 continuously, data_a=1, data_b=0 → grants alternate A,B,A,B starting with A; out_data sequence 1,0,1,0 starting 2 cycles after the first grant.
- out_ready=0, single requester A → exactly 2 grants, then gnt_a=0 and out_valid=1 held stable; raising out_ready → the third grant occurs in that same cycle.
- Pipeline full, flush=1 with req_b=1 and out_ready=1 → no gnt_b; next cycle out_valid=0, pipe_rst_n=0; RUN re-entered after 4 edges; prio unchanged.
- Assert rst low mid-stream, asynchronously between edges → out_valid, out_data, pipe_rst_n and gnts go to 0 immediately; prio=A after release.
- Only req_b toggling each cycle while req_a=0 → gnt_b whenever req_b=1; gnt_a never asserts.

Source files
------------

// File: rtl/search_pipe_arb_ctrl.sv
// Round-robin front end, two-stage valid/ready pipeline and staged reset release
// for a downstream datapath whose flops use async active-low reset pins.
module search_pipe_arb_ctrl #(
  parameter int WIDTH    = 1,
  parameter int RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             pipe_rst_n,
  output logic             busy
);

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic             prio_b_q, prio_b_d;
  logic             prst_q, prst_d;
  logic             busy_q, busy_d;

  logic adv2_s, s2_load_s, adv1_s, s1_acc_s, gnt_a_s, gnt_b_s;

  // Handshake and grant decode; prio_b_q set means B wins a tie.
  always_comb begin
    adv2_s    = v2_q & out_ready;
    s2_load_s = ~v2_q | adv2_s;
    adv1_s    = v1_q & s2_load_s;
    s1_acc_s  = (state_q == ST_RUN) & ~flush & (~v1_q | adv1_s);
    gnt_a_s   = s1_acc_s & req_a & (~req_b | ~prio_b_q);
    gnt_b_s   = s1_acc_s & req_b & (~req_a | prio_b_q);
  end

  // Next-state for sequencer, stage registers and arbitration priority.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    prio_b_d = prio_b_q;
    prst_d   = prst_q;
    case (state_q)
      ST_HOLD: begin
        if (flush) begin
          cnt_d = 8'd0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
          prst_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
          prst_d  = 1'b0;
          v1_d    = 1'b0;
          v2_d    = 1'b0;
          s1_d    = {WIDTH{1'b0}};
          s2_d    = {WIDTH{1'b0}};
        end else begin
          if (adv1_s) begin
            s2_d = s1_q;
            v2_d = 1'b1;
          end else if (adv2_s) begin
            v2_d = 1'b0;
          end else begin
            v2_d = v2_q;
          end
          if (gnt_a_s) begin
            s1_d     = data_a;
            v1_d     = 1'b1;
            prio_b_d = 1'b1;
          end else if (gnt_b_s) begin
            s1_d     = data_b;
            v1_d     = 1'b1;
            prio_b_d = 1'b0;
          end else if (adv1_s) begin
            v1_d = 1'b0;
          end else begin
            v1_d = v1_q;
          end
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = 8'd0;
        prst_d  = 1'b0;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_RUN) | v1_d | v2_d;
  end

  // State register bank with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_HOLD;
      cnt_q    <= 8'd0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      s1_q     <= {WIDTH{1'b0}};
      s2_q     <= {WIDTH{1'b0}};
      prio_b_q <= 1'b0;
      prst_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prio_b_q <= prio_b_d;
      prst_q   <= prst_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_a      = gnt_a_s;
  assign gnt_b      = gnt_b_s;
  assign out_valid  = v2_q;
  assign out_data   = s2_q;
  assign pipe_rst_n = prst_q;
  assign busy       = busy_q;

endmodule
